// File: rtl/mem_bridge_if.sv
// Request bus from the sequencer plus the 8-bit asynchronous SRAM pins, bundled for mem_bridge.
// The bridge connects through the slave modport; the requester/SRAM side uses master.
interface mem_bridge_if #(
    parameter int ADDR_W = 20
) ();
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_size;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              busy;
    logic              fault;
    logic [ADDR_W-1:0] ext_addr;
    logic [7:0]        ext_dout;
    logic [7:0]        ext_din;
    logic              ext_oe_n;
    logic              ext_we_n;

    modport master (
        output addr, wdata, mem_read, mem_write, mem_size, ext_din,
        input  rdata, rdata_valid, busy, fault, ext_addr, ext_dout, ext_oe_n, ext_we_n
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write, mem_size, ext_din,
        output rdata, rdata_valid, busy, fault, ext_addr, ext_dout, ext_oe_n, ext_we_n
    );
endinterface

// File: rtl/mem_bridge.sv
// Converts 32-bit load/store/fetch requests into byte-serial cycles on an 8-bit async SRAM,
// stalling the requester and returning sign/zero-extended load data.
module mem_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_bridge_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        wait_q, wait_d;
    logic [3:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic              we_n_q;

    logic              req, conflict, misalign, accept;
    logic              in_byte, in_half, in_word;
    logic              wait_done, we_low;
    logic [1:0]        last_cnt;
    logic [31:0]       asm_data;
    logic              unused_addr;

    assign unused_addr = ^bus.addr;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [3:0] size);
        logic [31:0] res;
        res = raw;
        if (size[3])      res = {{24{raw[7]}}, raw[7:0]};
        else if (size[2]) res = {24'd0, raw[7:0]};
        else if (size[1]) res = {{16{raw[15]}}, raw[15:0]};
        else if (size[0]) res = {16'd0, raw[15:0]};
        return res;
    endfunction

    // Request decode, evaluated against the live inputs while IDLE.
    assign req      = bus.mem_read ^ bus.mem_write;
    assign conflict = bus.mem_read & bus.mem_write;
    assign in_byte  = bus.mem_size[3] | bus.mem_size[2];
    assign in_half  = !in_byte && (bus.mem_size[1] | bus.mem_size[0]);
    assign in_word  = !in_byte && !in_half;
    assign misalign = (in_half && bus.addr[0]) || (in_word && (bus.addr[1:0] != 2'b00));
    assign accept   = req && !misalign;

    always_comb begin
        if (size_q[3] | size_q[2])      last_cnt = 2'd0;
        else if (size_q[1] | size_q[0]) last_cnt = 2'd1;
        else                            last_cnt = 2'd3;
    end

    assign wait_done = (wait_q == WAIT_LAST);

    // Load buffer with the byte currently on the SRAM pins merged into its lane.
    always_comb begin
        asm_data = buf_q;
        asm_data[{cnt_q, 3'b000} +: 8] = bus.ext_din;
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        size_d     = size_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        ext_addr_d = ext_addr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_XFER;
                    cnt_d      = 2'd0;
                    wait_d     = 3'd0;
                    size_d     = bus.mem_size;
                    write_d    = bus.mem_write;
                    wdata_d    = bus.mem_write ? bus.wdata : 32'd0;
                    buf_d      = 32'd0;
                    ext_addr_d = bus.addr[ADDR_W-1:0];
                end
            end
            S_XFER: begin
                if (wait_done) begin
                    wait_d = 3'd0;
                    if (!write_q) buf_d = asm_data;
                    if (cnt_q == last_cnt) begin
                        state_d = S_DONE;
                        if (!write_q) begin
                            rdata_d  = extend(asm_data, size_q);
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        cnt_d      = cnt_q + 2'd1;
                        ext_addr_d = ext_addr_q + 1'b1;
                        wdata_d    = wdata_q >> 8;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            wait_q     <= 3'd0;
            size_q     <= 4'd0;
            write_q    <= 1'b0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            ext_addr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples
            // the pre-edge values, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            size_q     <= size_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            ext_addr_q <= ext_addr_d;
        end
    end

    // Strobe is retimed to the falling edge so address/data settle half a cycle either side.
    assign we_low = (state_q == S_XFER) && write_q && ((WAIT_LAST == 3'd0) || !wait_done);

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) we_n_q <= 1'b1;
        else          we_n_q <= !we_low;
    end

    assign bus.busy        = reset_n && (((state_q == S_IDLE) && accept) || (state_q == S_XFER));
    assign bus.fault       = reset_n && (state_q == S_IDLE) && (conflict || (req && misalign));
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.ext_addr    = ext_addr_q;
    assign bus.ext_dout    = wdata_q[7:0];
    assign bus.ext_oe_n    = !((state_q == S_XFER) && !write_q);
    assign bus.ext_we_n    = we_n_q;
endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: unit 0 runs with no wait states, unit 1 with two,
// each attached to its own behavioural 4 KiB SRAM.
module tb_mem_bridge;
    logic clk;
    logic reset_n;

    mem_bridge_if #(.ADDR_W(20)) bus0 ();
    mem_bridge_if #(.ADDR_W(20)) bus1 ();

    mem_bridge #(.ADDR_W(20), .WAIT_STATES(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    mem_bridge #(.ADDR_W(20), .WAIT_STATES(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  sram0 [0:4095];
    logic [7:0]  sram1 [0:4095];
    logic        bd_en;
    int          bd_unit;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;

    // SRAM commits a byte at the end of each cycle the write strobe was low.
    always @(posedge clk) begin
        if (bd_en) begin
            if (bd_unit == 0) sram0[bd_addr] <= bd_data;
            else              sram1[bd_addr] <= bd_data;
        end
        if (!bus0.ext_we_n) sram0[bus0.ext_addr[11:0]] <= bus0.ext_dout;
        if (!bus1.ext_we_n) sram1[bus1.ext_addr[11:0]] <= bus1.ext_dout;
    end

    assign bus0.ext_din = sram0[bus0.ext_addr[11:0]];
    assign bus1.ext_din = sram1[bus1.ext_addr[11:0]];

    int          sel;
    logic        busy_s, fault_s, oe_s, we_s, rv_s;
    logic [31:0] rdata_s;
    logic [19:0] ea_s;

    assign busy_s  = (sel == 1) ? bus1.busy        : bus0.busy;
    assign fault_s = (sel == 1) ? bus1.fault       : bus0.fault;
    assign oe_s    = (sel == 1) ? bus1.ext_oe_n    : bus0.ext_oe_n;
    assign we_s    = (sel == 1) ? bus1.ext_we_n    : bus0.ext_we_n;
    assign rv_s    = (sel == 1) ? bus1.rdata_valid : bus0.rdata_valid;
    assign rdata_s = (sel == 1) ? bus1.rdata       : bus0.rdata;
    assign ea_s    = (sel == 1) ? bus1.ext_addr    : bus0.ext_addr;

    int total = 0;
    int bad   = 0;
    logic [19:0] trace [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic poke(input int unit, input logic [11:0] a, input logic [7:0] d);
        bd_unit = unit;
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        step();
        bd_en   = 1'b0;
    endtask

    task automatic drive(input int unit, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sz);
        if (unit == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = wd; bus0.mem_size = sz;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.wdata = wd; bus1.mem_size = sz;
        end
    endtask

    // Issues one request and holds it until busy drops; returns at mid-cycle of DONE.
    task automatic access(input int unit, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] sz,
                          output int bcyc, output int oecyc, output int wecyc);
        sel = unit;
        bcyc = 0; oecyc = 0; wecyc = 0;
        step();
        drive(unit, rd, wr, a, wd, sz);
        for (int k = 0; k < 40; k++) begin
            mid();
            if (!busy_s) break;
            if (k < 16) trace[k] = ea_s;
            bcyc++;
            if (!oe_s) oecyc++;
            if (!we_s) wecyc++;
            step();
        end
        drive(unit, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    int b, o, w;

    initial begin
        reset_n = 1'b0;
        sel     = 0;
        bd_en   = 1'b0;
        bd_unit = 0;
        bd_addr = 12'd0;
        bd_data = 8'd0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        poke(0, 12'h101, 8'h80);
        poke(0, 12'h200, 8'h34);
        poke(0, 12'h201, 8'hF2);
        for (int i = 0; i < 4; i++) poke(0, 12'h300 + 12'(i), 8'h00);
        for (int i = 0; i < 4; i++) poke(0, 12'h400 + 12'(i), 8'hEE);
        poke(1, 12'h000, 8'h11);
        poke(1, 12'h001, 8'h22);
        poke(1, 12'h002, 8'h33);
        poke(1, 12'h003, 8'h44);

        // Reset state
        mid();
        check("rst_rdata",  bus0.rdata, 32'h0);
        check("rst_rvalid", bus0.rdata_valid, 1'b0);
        check("rst_busy",   bus0.busy, 1'b0);
        check("rst_fault",  bus0.fault, 1'b0);
        check("rst_oe_n",   bus0.ext_oe_n, 1'b1);
        check("rst_we_n",   bus0.ext_we_n, 1'b1);
        check("rst_addr",   bus0.ext_addr, 20'h0);
        check("rst_dout",   bus0.ext_dout, 8'h0);
        check("rst_busy1",  bus1.busy, 1'b0);
        step();
        reset_n = 1'b1;

        // lb at odd address, sign-extended
        access(0, 1'b1, 1'b0, 32'h00101, 32'd0, 4'b1000, b, o, w);
        check("lb_busy", b, 2);
        check("lb_oe",   o, 1);
        check("lb_we",   w, 0);
        check("lb_addr", trace[1], 20'h00101);
        check("lb_rv",   rv_s, 1'b1);
        check("lb_data", rdata_s, 32'hFFFFFF80);

        // lhu / lh at the same halfword
        access(0, 1'b1, 1'b0, 32'h00200, 32'd0, 4'b0001, b, o, w);
        check("lhu_busy", b, 3);
        check("lhu_data", rdata_s, 32'h0000F234);
        access(0, 1'b1, 1'b0, 32'h00200, 32'd0, 4'b0010, b, o, w);
        check("lh_data", rdata_s, 32'hFFFFF234);
        step(); mid();
        check("rv_drop",  rv_s, 1'b0);
        check("rd_hold",  rdata_s, 32'hFFFFF234);

        // sw, little-endian byte order
        access(0, 1'b0, 1'b1, 32'h00300, 32'h12345678, 4'b0000, b, o, w);
        check("sw_busy", b, 5);
        check("sw_we",   w, 4);
        check("sw_oe",   o, 0);
        check("sw_rv",   rv_s, 1'b0);
        check("sw_hold", rdata_s, 32'hFFFFF234);
        check("sw_mem",  {sram0[12'h303], sram0[12'h302], sram0[12'h301], sram0[12'h300]}, 32'h12345678);
        access(0, 1'b1, 1'b0, 32'h00300, 32'd0, 4'b0000, b, o, w);
        check("lw_data", rdata_s, 32'h12345678);

        // sb then lbu at the same odd byte
        access(0, 1'b0, 1'b1, 32'h00305, 32'h000000AB, 4'b1000, b, o, w);
        check("sb_we",  w, 1);
        check("sb_mem", sram0[12'h305], 8'hAB);
        access(0, 1'b1, 1'b0, 32'h00305, 32'd0, 4'b0100, b, o, w);
        check("lbu_data", rdata_s, 32'h000000AB);

        // Faults: misaligned word, misaligned half, read+write conflict
        sel = 0;
        step(); drive(0, 1'b1, 1'b0, 32'h00302, 32'd0, 4'b0000); mid();
        check("flw_fault", fault_s, 1'b1);
        check("flw_busy",  busy_s, 1'b0);
        step(); drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); mid();
        check("flw_pulse", fault_s, 1'b0);
        check("flw_oe",    oe_s, 1'b1);
        check("flw_we",    we_s, 1'b1);
        check("flw_idle",  busy_s, 1'b0);
        step(); drive(0, 1'b1, 1'b0, 32'h00201, 32'd0, 4'b0001); mid();
        check("flh_fault", fault_s, 1'b1);
        step(); drive(0, 1'b1, 1'b1, 32'h00100, 32'd0, 4'b1000); mid();
        check("frw_fault", fault_s, 1'b1);
        check("frw_busy",  busy_s, 1'b0);
        step(); drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); mid();
        check("frw_oe",    oe_s, 1'b1);
        check("frw_we",    we_s, 1'b1);

        // Two wait states: lw and sb
        access(1, 1'b1, 1'b0, 32'h00000, 32'd0, 4'b0000, b, o, w);
        check("ws_busy",  b, 13);
        check("ws_oe",    o, 12);
        check("ws_a0",    trace[3], 20'h0);
        check("ws_a1",    trace[4], 20'h1);
        check("ws_a3",    trace[12], 20'h3);
        check("ws_data",  rdata_s, 32'h44332211);
        check("ws_rv",    rv_s, 1'b1);
        access(1, 1'b0, 1'b1, 32'h00010, 32'h000000AB, 4'b1000, b, o, w);
        check("ws_sb_busy", b, 4);
        check("ws_sb_we",   w, 2);
        check("ws_sb_mem",  sram1[12'h010], 8'hAB);

        // Reset during byte 2 of a store
        sel = 0;
        step(); drive(0, 1'b0, 1'b1, 32'h00400, 32'hA1B2C3D4, 4'b0000); mid();
        step(); mid();
        step(); mid();
        step(); mid();
        check("mr_we_low", we_s, 1'b0);
        check("mr_addr",   ea_s, 20'h00402);
        reset_n = 1'b0;
        #1;
        check("mr_we_n",  we_s, 1'b1);
        check("mr_busy",  busy_s, 1'b0);
        check("mr_fault", fault_s, 1'b0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step(); step();
        reset_n = 1'b1;
        mid();
        check("mr_idle",  busy_s, 1'b0);
        check("mr_oe",    oe_s, 1'b1);
        check("mr_rdata", rdata_s, 32'h0);
        check("mr_mem",   {sram0[12'h403], sram0[12'h402], sram0[12'h401], sram0[12'h400]}, 32'hEEEEC3D4);
        access(0, 1'b1, 1'b0, 32'h00401, 32'd0, 4'b0100, b, o, w);
        check("mr_lbu_busy", b, 2);
        check("mr_lbu_data", rdata_s, 32'h000000C3);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
